multicycle_ctrl: RTL and testbench

- Central FSM that sequences the 16-bit processor datapath (fetch, decode, execute, memory, writeback) over multiple cycles instead of one.
- Decodes opcode bits [15:12] from the instruction register.
- Drives every datapath control strobe and handshakes with the shared instruction/data memory through a req/ready pair.
- Sits beside the datapath top level and replaces per-stage hardwired control.

---
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between multicycle_ctrl (master) and the datapath plus
// shared instruction/data memory (slave).
interface multicycle_ctrl_if;
  // Handshake: the controller holds mem_req (with mem_read/mem_write/i_or_d stable)
  // until a cycle in which mem_ready = 1; that cycle completes the access.
  // mem_ready is meaningless whenever mem_req = 0.
  logic       enable;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;
  logic       mem_err;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  enable, opcode, zero, mem_ready,
    output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op,
           mem_err, halted, state
  );

  modport slave (
    output enable, opcode, zero, mem_ready,
    input  mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op,
           mem_err, halted, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FSM sequencing the 16-bit datapath: fetch, decode, execute, memory, writeback.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_count / instr_count performance counters.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  multicycle_ctrl_if.master   bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]         cycle_count,
  output logic [31:0]         instr_count
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_mem_err;
  logic            r_halted;

  state_t          w_next;
  logic            w_legal;
  logic            w_to_hit;
  logic            w_fault;
  logic            w_mem_req;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_i_or_d;
  logic            w_ir_write;
  logic            w_pc_write;
  logic [1:0]      w_pc_src;
  logic [1:0]      w_alu_src_b;
  logic [1:0]      w_alu_op;
  logic            w_reg_dst;
  logic            w_mem_to_reg;
  logic            w_reg_write;
  logic            w_illegal_op;

  // Opcodes that run through EXEC; HALT is recognised separately.
  assign w_legal  = (bus.opcode == OP_R)   || (bus.opcode == OP_ADDI) ||
                    (bus.opcode == OP_LW)  || (bus.opcode == OP_SW)   ||
                    (bus.opcode == OP_BEQ) || (bus.opcode == OP_J);
  assign w_to_hit = (r_to_cnt == TO_LIMIT);

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal_op = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (bus.enable) begin
          w_mem_req  = 1'b1;
          w_mem_read = 1'b1;
          if (bus.mem_ready) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            w_pc_src   = 2'b00;
            w_next     = ST_DECODE;
          end else if (w_to_hit) begin
            w_next = ST_HALTED;
          end
        end
      end

      ST_DECODE: begin
        if (bus.opcode == OP_HALT) begin
          w_next = ST_HALTED;
        end else if (w_legal) begin
          w_next = ST_EXEC;
        end else begin
          w_illegal_op = 1'b1;
          w_next       = ST_FETCH;
        end
      end

      ST_EXEC: begin
        case (bus.opcode)
          OP_R: begin
            w_alu_src_b = 2'b00;
            w_alu_op    = 2'b10;
            w_next      = ST_WB;
          end
          OP_ADDI: begin
            w_alu_src_b = 2'b01;
            w_alu_op    = 2'b00;
            w_next      = ST_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_src_b = 2'b01;
            w_alu_op    = 2'b00;
            w_next      = ST_MEM;
          end
          OP_BEQ: begin
            w_alu_src_b = 2'b00;
            w_alu_op    = 2'b01;
            w_pc_write  = bus.zero;
            w_pc_src    = 2'b01;
            w_next      = ST_FETCH;
          end
          OP_J: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b10;
            w_next     = ST_FETCH;
          end
          default: w_next = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        w_mem_req   = 1'b1;
        w_i_or_d    = 1'b1;
        w_mem_read  = (bus.opcode == OP_LW);
        w_mem_write = (bus.opcode == OP_SW);
        if (bus.mem_ready) begin
          w_next = (bus.opcode == OP_LW) ? ST_WB : ST_FETCH;
        end else if (w_to_hit) begin
          w_next = ST_HALTED;
        end
      end

      ST_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (bus.opcode == OP_R);
        w_mem_to_reg = (bus.opcode == OP_LW);
        w_next       = ST_FETCH;
      end

      ST_HALTED: w_next = ST_HALTED;

      default: w_next = ST_FETCH;
    endcase
  end

  // A ready arriving on the limit cycle takes the normal path, so the fault needs ~mem_ready.
  assign w_fault = w_mem_req && !bus.mem_ready && w_to_hit;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= ST_FETCH;
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (w_mem_req && bus.mem_ready)) begin
        r_to_cnt <= '0;
      end else if (w_mem_req) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_fault) begin
        r_mem_err <= 1'b1;
      end
      if (w_next == ST_HALTED) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Everything is forced low while reset_n is asserted, including the debug state.
  assign bus.mem_req    = reset_n & w_mem_req;
  assign bus.mem_read   = reset_n & w_mem_read;
  assign bus.mem_write  = reset_n & w_mem_write;
  assign bus.i_or_d     = reset_n & w_i_or_d;
  assign bus.ir_write   = reset_n & w_ir_write;
  assign bus.pc_write   = reset_n & w_pc_write;
  assign bus.pc_src     = {2{reset_n}} & w_pc_src;
  assign bus.alu_src_b  = {2{reset_n}} & w_alu_src_b;
  assign bus.alu_op     = {2{reset_n}} & w_alu_op;
  assign bus.reg_dst    = reset_n & w_reg_dst;
  assign bus.mem_to_reg = reset_n & w_mem_to_reg;
  assign bus.reg_write  = reset_n & w_reg_write;
  assign bus.illegal_op = reset_n & w_illegal_op;
  assign bus.mem_err    = reset_n & r_mem_err;
  assign bus.halted     = reset_n & r_halted;
  assign bus.state      = reset_n ? r_state : ST_FETCH;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (r_state != ST_HALTED) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if ((r_state == ST_DECODE) && w_legal) begin
        r_instr_count <= r_instr_count + 32'd1;
      end
    end
  end

  assign cycle_count = reset_n ? r_cycle_count : 32'd0;
  assign instr_count = reset_n ? r_instr_count : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: the driver queues hand-computed output
// vectors per cycle, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;
  localparam int W = 21;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_BAD  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Clock / reset
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_count (cycle_count),
    .instr_count (instr_count)
`endif
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] w_act;
  assign w_act = {bus.state, bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d,
                  bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src_b, bus.alu_op,
                  bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal_op,
                  bus.mem_err, bus.halted};

  // mb = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write}
  // tl = {reg_dst, mem_to_reg, reg_write, illegal_op, mem_err, halted}
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [5:0] mb,
                                      input logic [1:0] pcs, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic [5:0] tl);
    return {st, mb, pcs, asb, aop, tl};
  endfunction

  logic [W-1:0] zero_v, f_hit, f_wait, dec_v;
  initial begin
    zero_v = mk(3'd0, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000000);
    f_hit  = mk(3'd0, 6'b110011, 2'b00, 2'b00, 2'b00, 6'b000000);
    f_wait = mk(3'd0, 6'b110000, 2'b00, 2'b00, 2'b00, 6'b000000);
    dec_v  = mk(3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000000);
  end

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b (state got %0d required %0d)",
                 nm, w_act, e, w_act[W-1 -: 3], e[W-1 -: 3]);
      end
    end
  end

  // Driver tasks
  task automatic drive(input string nm, input logic rn, input logic en, input logic [3:0] op,
                       input logic z, input logic rdy, input logic [W-1:0] e);
    reset_n       = rn;
    bus.enable    = en;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic s(input string nm, input logic en, input logic [3:0] op, input logic z,
                   input logic rdy, input logic [W-1:0] e);
    drive(nm, 1'b1, en, op, z, rdy, e);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.enable    = 1'b0;
    bus.opcode    = 4'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    drive("reset0", 1'b0, 1'b1, OP_SW, 1'b1, 1'b1, zero_v);
    drive("reset1", 1'b0, 1'b1, OP_SW, 1'b1, 1'b1, zero_v);

    // enable low in FETCH: nothing moves, mem_ready ignored
    s("en_off0", 1'b0, OP_R, 1'b0, 1'b1, zero_v);
    s("en_off1", 1'b0, OP_R, 1'b0, 1'b0, zero_v);

    // R-type
    s("r_fetch",  1'b1, OP_R, 1'b0, 1'b1, f_hit);
    s("r_decode", 1'b1, OP_R, 1'b0, 1'b1, dec_v);
    s("r_exec",   1'b1, OP_R, 1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b10, 6'b000000));
    s("r_wb",     1'b1, OP_R, 1'b0, 1'b1, mk(3'd4, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b101000));

    // ADDI
    s("addi_fetch",  1'b1, OP_ADDI, 1'b0, 1'b1, f_hit);
    s("addi_decode", 1'b1, OP_ADDI, 1'b0, 1'b1, dec_v);
    s("addi_exec",   1'b1, OP_ADDI, 1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b00, 2'b01, 2'b00, 6'b000000));
    s("addi_wb",     1'b1, OP_ADDI, 1'b0, 1'b1, mk(3'd4, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b001000));

    // LW with two MEM wait cycles: 7 cycles total
    s("lw_fetch",  1'b1, OP_LW, 1'b0, 1'b1, f_hit);
    s("lw_decode", 1'b1, OP_LW, 1'b0, 1'b1, dec_v);
    s("lw_exec",   1'b1, OP_LW, 1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b00, 2'b01, 2'b00, 6'b000000));
    s("lw_mem_w0", 1'b1, OP_LW, 1'b0, 1'b0, mk(3'd3, 6'b110100, 2'b00, 2'b00, 2'b00, 6'b000000));
    s("lw_mem_w1", 1'b1, OP_LW, 1'b0, 1'b0, mk(3'd3, 6'b110100, 2'b00, 2'b00, 2'b00, 6'b000000));
    s("lw_mem_ok", 1'b1, OP_LW, 1'b0, 1'b1, mk(3'd3, 6'b110100, 2'b00, 2'b00, 2'b00, 6'b000000));
    s("lw_wb",     1'b1, OP_LW, 1'b0, 1'b1, mk(3'd4, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b011000));

    // SW zero-wait, fetch with a couple of wait cycles first
    s("sw_fetch_w0", 1'b1, OP_SW, 1'b0, 1'b0, f_wait);
    s("sw_fetch_w1", 1'b1, OP_SW, 1'b0, 1'b0, f_wait);
    s("sw_fetch",    1'b1, OP_SW, 1'b0, 1'b1, f_hit);
    s("sw_decode",   1'b1, OP_SW, 1'b0, 1'b1, dec_v);
    s("sw_exec",     1'b1, OP_SW, 1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b00, 2'b01, 2'b00, 6'b000000));
    s("sw_mem",      1'b1, OP_SW, 1'b0, 1'b1, mk(3'd3, 6'b101100, 2'b00, 2'b00, 2'b00, 6'b000000));

    // BEQ taken then not taken
    s("beq1_fetch",  1'b1, OP_BEQ, 1'b1, 1'b1, f_hit);
    s("beq1_decode", 1'b1, OP_BEQ, 1'b1, 1'b1, dec_v);
    s("beq1_exec",   1'b1, OP_BEQ, 1'b1, 1'b1, mk(3'd2, 6'b000001, 2'b01, 2'b00, 2'b01, 6'b000000));
    s("beq0_fetch",  1'b1, OP_BEQ, 1'b0, 1'b1, f_hit);
    s("beq0_decode", 1'b1, OP_BEQ, 1'b0, 1'b1, dec_v);
    s("beq0_exec",   1'b1, OP_BEQ, 1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b01, 2'b00, 2'b01, 6'b000000));

    // J
    s("j_fetch",  1'b1, OP_J, 1'b0, 1'b1, f_hit);
    s("j_decode", 1'b1, OP_J, 1'b0, 1'b1, dec_v);
    s("j_exec",   1'b1, OP_J, 1'b0, 1'b1, mk(3'd2, 6'b000001, 2'b10, 2'b00, 2'b00, 6'b000000));

    // Undefined opcode: one-cycle illegal_op, back to FETCH
    s("bad_fetch",  1'b1, OP_BAD, 1'b0, 1'b1, f_hit);
    s("bad_decode", 1'b1, OP_BAD, 1'b0, 1'b1, mk(3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000100));
    s("bad_after",  1'b1, OP_BAD, 1'b0, 1'b0, f_wait);
    s("bad_after2", 1'b1, OP_R,   1'b0, 1'b1, f_hit);
    s("bad_r_dec",  1'b1, OP_R,   1'b0, 1'b1, dec_v);
    s("bad_r_exec", 1'b1, OP_R,   1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b00, 2'b00, 2'b10, 6'b000000));
    s("bad_r_wb",   1'b1, OP_R,   1'b0, 1'b1, mk(3'd4, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b101000));

    // Reset during an SW memory wait: no store after release
    s("swr_fetch",  1'b1, OP_SW, 1'b0, 1'b1, f_hit);
    s("swr_decode", 1'b1, OP_SW, 1'b0, 1'b1, dec_v);
    s("swr_exec",   1'b1, OP_SW, 1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b00, 2'b01, 2'b00, 6'b000000));
    s("swr_mem_w",  1'b1, OP_SW, 1'b0, 1'b0, mk(3'd3, 6'b101100, 2'b00, 2'b00, 2'b00, 6'b000000));
    drive("swr_reset", 1'b0, 1'b1, OP_SW, 1'b0, 1'b1, zero_v);
    s("swr_post0",  1'b0, OP_SW, 1'b0, 1'b1, zero_v);
    s("swr_post1",  1'b1, OP_SW, 1'b0, 1'b0, f_wait);
    s("swr_post2",  1'b1, OP_SW, 1'b0, 1'b1, f_hit);
    s("swr_post3",  1'b1, OP_ADDI, 1'b0, 1'b1, dec_v);
    s("swr_post4",  1'b1, OP_ADDI, 1'b0, 1'b1, mk(3'd2, 6'b000000, 2'b00, 2'b01, 2'b00, 6'b000000));
    s("swr_post5",  1'b1, OP_ADDI, 1'b0, 1'b1, mk(3'd4, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b001000));

    // mem_ready on the limit cycle wins: 15 waits, ready on the 16th FETCH cycle
    for (int i = 0; i < 15; i++) s("edge_wait", 1'b1, OP_J, 1'b0, 1'b0, f_wait);
    s("edge_hit",    1'b1, OP_J, 1'b0, 1'b1, f_hit);
    s("edge_decode", 1'b1, OP_J, 1'b0, 1'b1, dec_v);
    s("edge_exec",   1'b1, OP_J, 1'b0, 1'b1, mk(3'd2, 6'b000001, 2'b10, 2'b00, 2'b00, 6'b000000));

    // HALT: halted from cycle 3, enable has no effect
    s("halt_fetch",  1'b1, OP_HALT, 1'b0, 1'b1, f_hit);
    s("halt_decode", 1'b1, OP_HALT, 1'b0, 1'b1, dec_v);
    s("halt_c3",     1'b1, OP_HALT, 1'b0, 1'b1, mk(3'd5, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000001));
    s("halt_en0",    1'b0, OP_R,    1'b0, 1'b1, mk(3'd5, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000001));
    s("halt_en1",    1'b1, OP_R,    1'b0, 1'b1, mk(3'd5, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000001));
    drive("halt_reset", 1'b0, 1'b1, OP_R, 1'b0, 1'b1, zero_v);
    s("halt_exit",   1'b1, OP_R, 1'b0, 1'b0, f_wait);

    // FETCH timeout: 16 waiting cycles, then HALTED with mem_err
    for (int i = 0; i < 15; i++) s("to_wait", 1'b1, OP_R, 1'b0, 1'b0, f_wait);
    s("to_halt0", 1'b1, OP_R, 1'b0, 1'b1, mk(3'd5, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000011));
    s("to_halt1", 1'b0, OP_R, 1'b0, 1'b1, mk(3'd5, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000011));
    s("to_halt2", 1'b1, OP_R, 1'b0, 1'b0, mk(3'd5, 6'b000000, 2'b00, 2'b00, 2'b00, 6'b000011));
    drive("to_reset", 1'b0, 1'b1, OP_R, 1'b0, 1'b0, zero_v);
    s("to_cleared", 1'b0, OP_R, 1'b0, 1'b0, zero_v);

    // Everything queued must have been consumed by the monitor
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
